// File: rtl/datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_fsm
//
// Moore controller sequencing a simple register-file / ALU / memory datapath.
// An instruction is requested with s while the controller idles in WAIT; the
// opcode/op fields are decoded in DECODE and captured into a small instruction
// register so that later states decode their outputs from internal state only.
//
// Optional feature macro: CTRL_LDST_EN
//   defined   : LDR (opcode 011) / STR (opcode 100) memory sequences are built.
//   undefined : those opcodes are treated as illegal; mem_cmd/load_addr stay 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (returns to WAIT)
//   s          in   start request, only looked at in WAIT
//   opcode[2:0]in   instruction bits [15:13], stable while w=0
//   op[1:0]    in   instruction bits [12:11], stable while w=0
//   w          out  idle/ready, 1 only in WAIT
//   nsel[2:0]  out  one-hot register select (Rn=001, Rd=010, Rm=100)
//   vsel[1:0]  out  writeback mux (00=C, 01=PC, 10=sximm8, 11=mdata)
//   loada/loadb/loadc/loads  out  datapath register enables
//   asel       out  force ALU A input to zero
//   bsel       out  select sximm5 as ALU B input
//   alu_op[1:0]out  ALU operation, ADD (00) outside of ALU instructions
//   write      out  register-file write strobe
//   mem_cmd[1:0]out 00=NONE, 01=READ, 10=WRITE
//   load_addr  out  data-address register enable
//   illegal    out  one-cycle pulse on an undecodable instruction
//   halted     out  1 while halted (left only through reset)
// -----------------------------------------------------------------------------
module datapath_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] alu_op,
  output logic       write,
  output logic [1:0] mem_cmd,
  output logic       load_addr,
  output logic       illegal,
  output logic       halted
);

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
`ifdef CTRL_LDST_EN
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  localparam logic [1:0] MEM_READ   = 2'b01;
  localparam logic [1:0] MEM_WRITE  = 2'b10;
  localparam logic [2:0] OPC_LDR    = 3'b011;
`endif
  localparam logic [1:0] MEM_NONE   = 2'b00;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  typedef enum logic [3:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_RD,
    S_ILL,
    S_HALT
`ifdef CTRL_LDST_EN
    ,
    S_ADDR,
    S_LD_ADDR,
    S_MEM_RD,
    S_WR_MEM,
    S_GET_D,
    S_PASS_B,
    S_MEM_WR
`endif
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] ir_opcode;
  logic [1:0] ir_op;

  logic is_cmp;
  logic is_mvn;
  logic is_mov_reg;

  assign is_cmp     = ({ir_opcode, ir_op} == 5'b101_01);
  assign is_mvn     = ({ir_opcode, ir_op} == 5'b101_11);
  assign is_mov_reg = ({ir_opcode, ir_op} == 5'b110_00);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchronous reset is simply the highest-priority branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT;
      ir_opcode <= '0;
      ir_op     <= '0;
    end else begin
      state <= state_next;
      // Upstream holds the fields stable from DECODE onward, so capturing them
      // here lets every later state decode from registered state alone.
      if (state == S_DECODE) begin
        ir_opcode <= opcode;
        ir_op     <= op;
      end
    end
  end

  // Next-state logic.
  // NOTE: the default assignment at the top of each always_comb is what keeps
  // synthesis from inferring a latch on paths that do not assign the signal.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (s) state_next = S_DECODE;
      S_DECODE: begin
        casez ({opcode, op})
          5'b110_10: state_next = S_WR_IMM;
          5'b110_00: state_next = S_GET_B;
          5'b101_11: state_next = S_GET_B;
          5'b101_??: state_next = S_GET_A;
`ifdef CTRL_LDST_EN
          5'b011_00: state_next = S_GET_A;
          5'b100_00: state_next = S_GET_A;
`endif
          5'b111_??: state_next = S_HALT;
          default:   state_next = S_ILL;
        endcase
      end
      S_WR_IMM: state_next = S_WAIT;
`ifdef CTRL_LDST_EN
      S_GET_A:  state_next = (ir_opcode == OPC_ALU) ? S_EXEC : S_ADDR;
`else
      S_GET_A:  state_next = S_EXEC;
`endif
      S_GET_B:  state_next = S_EXEC;
      // CMP only updates status; everything else writes its result back.
      S_EXEC:   state_next = is_cmp ? S_WAIT : S_WR_RD;
      S_WR_RD:  state_next = S_WAIT;
      S_ILL:    state_next = S_WAIT;
      S_HALT:   state_next = S_HALT;
`ifdef CTRL_LDST_EN
      S_ADDR:    state_next = S_LD_ADDR;
      S_LD_ADDR: state_next = (ir_opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
      S_MEM_RD:  state_next = S_WR_MEM;
      S_WR_MEM:  state_next = S_WAIT;
      S_GET_D:   state_next = S_PASS_B;
      S_PASS_B:  state_next = S_MEM_WR;
      S_MEM_WR:  state_next = S_WAIT;
`endif
      default:  state_next = S_WAIT;
    endcase
  end

  // Moore output decode: everything idles at zero unless the state says so.
  always_comb begin
    w         = 1'b0;
    nsel      = NSEL_NONE;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    alu_op    = 2'b00;
    write     = 1'b0;
    mem_cmd   = MEM_NONE;
    load_addr = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: ;
      S_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        // MOV-reg and MVN operate on B alone, so A is forced to zero.
        asel = is_mov_reg | is_mvn;
        if (ir_opcode == OPC_ALU) alu_op = ir_op;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WR_RD: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ILL:  illegal = 1'b1;
      S_HALT: halted  = 1'b1;
`ifdef CTRL_LDST_EN
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd   = MEM_READ;
      S_WR_MEM: begin
        // Read is held a second cycle so mdata is valid while Rd is written.
        mem_cmd = MEM_READ;
        vsel    = VSEL_MDATA;
        nsel    = NSEL_RD;
        write   = 1'b1;
      end
      S_GET_D: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_PASS_B: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WRITE;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl_fsm
//
// Scoreboard bench: the stimulus process issues instructions and pushes the
// per-cycle output trace that each instruction class must produce; a separate
// monitor pops one expected output vector per cycle and compares it with the
// DUT. Honour CTRL_LDST_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl_fsm;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] alu_op;
    logic       write;
    logic [1:0] mem_cmd;
    logic       load_addr;
    logic       illegal;
    logic       halted;
  } outs_t;

`ifdef CTRL_LDST_EN
  localparam bit LDST_EN = 1'b1;
`else
  localparam bit LDST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write, load_addr, illegal, halted;
  logic [2:0] nsel;
  logic [1:0] vsel, alu_op, mem_cmd;

  outs_t act;
  assign act = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel,
                alu_op, write, mem_cmd, load_addr, illegal, halted};

  datapath_ctrl_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .alu_op(alu_op),
    .write(write), .mem_cmd(mem_cmd), .load_addr(load_addr),
    .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  outs_t sb[$];
  outs_t exp_tr[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: one expected vector per cycle while the scoreboard holds entries.
  initial begin
    outs_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("outputs", 32'(act), 32'(e));
      end
    end
  end

  function automatic outs_t v_wait();
    outs_t v = '0;
    v.w = 1'b1;
    return v;
  endfunction

  // Reference: the cycle-by-cycle output pattern of each instruction class,
  // starting with the decode cycle and ending with the return to WAIT.
  function automatic void build_trace(input logic [2:0] oc, input logic [1:0] o);
    outs_t v;
    exp_tr.delete();
    exp_tr.push_back('0);                                  // decode cycle
    if (oc == 3'b110 && o == 2'b10) begin                  // MOV imm
      v = '0; v.nsel = 3'b001; v.vsel = 2'b10; v.write = 1'b1; exp_tr.push_back(v);
    end else if ((oc == 3'b110 && o == 2'b00) || (oc == 3'b101 && o == 2'b11)) begin
      // MOV reg / MVN: read Rm, pass it through with A zeroed, write Rd
      v = '0; v.nsel = 3'b100; v.loadb = 1'b1; exp_tr.push_back(v);
      v = '0; v.asel = 1'b1; v.loadc = 1'b1; v.alu_op = (oc == 3'b101) ? o : 2'b00;
      exp_tr.push_back(v);
      v = '0; v.nsel = 3'b010; v.write = 1'b1; exp_tr.push_back(v);
    end else if (oc == 3'b101) begin                       // ADD / CMP / AND
      v = '0; v.nsel = 3'b001; v.loada = 1'b1; exp_tr.push_back(v);
      v = '0; v.alu_op = o;
      if (o == 2'b01) v.loads = 1'b1; else v.loadc = 1'b1;
      exp_tr.push_back(v);
      if (o != 2'b01) begin
        v = '0; v.nsel = 3'b010; v.write = 1'b1; exp_tr.push_back(v);
      end
    end else if (LDST_EN && o == 2'b00 && (oc == 3'b011 || oc == 3'b100)) begin
      v = '0; v.nsel = 3'b001; v.loada = 1'b1; exp_tr.push_back(v);
      v = '0; v.bsel = 1'b1; v.loadc = 1'b1; exp_tr.push_back(v);
      v = '0; v.load_addr = 1'b1; exp_tr.push_back(v);
      if (oc == 3'b011) begin                              // LDR
        v = '0; v.mem_cmd = 2'b01; exp_tr.push_back(v);
        v.vsel = 2'b11; v.nsel = 3'b010; v.write = 1'b1; exp_tr.push_back(v);
      end else begin                                       // STR
        v = '0; v.nsel = 3'b010; v.loadb = 1'b1; exp_tr.push_back(v);
        v = '0; v.asel = 1'b1; v.loadc = 1'b1; exp_tr.push_back(v);
        v = '0; v.mem_cmd = 2'b10; exp_tr.push_back(v);
      end
    end else begin                                         // undecodable
      v = '0; v.illegal = 1'b1; exp_tr.push_back(v);
    end
    exp_tr.push_back(v_wait());
  endfunction

  // Called at a falling edge while the DUT sits in WAIT; returns at the falling
  // edge of the WAIT cycle that ends the instruction.
  task automatic run_instr(input logic [2:0] oc, input logic [1:0] o, input bit hold);
    opcode = oc;
    op     = o;
    s      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) s = 1'b0;
    build_trace(oc, o);
    foreach (exp_tr[i]) sb.push_back(exp_tr[i]);
    repeat (exp_tr.size()) @(negedge clk);
  endtask

  task automatic idle(input int n);
    s = 1'b0;
    repeat (n) begin
      opcode = 3'($urandom);
      op     = 2'($urandom);
      @(posedge clk);
      #1 sb.push_back(v_wait());
      @(negedge clk);
    end
  endtask

  // Directed list: every decode row plus a few undecodable encodings.
  logic [4:0] directed [14] = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_01,
                                5'b101_00, 5'b101_10, 5'b011_00, 5'b100_00,
                                5'b000_00, 5'b010_11, 5'b110_01, 5'b110_11,
                                5'b011_01, 5'b100_10};

  initial begin
    outs_t v;
    reset  = 1'b1;
    s      = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;
    // Reset state, with s high to show reset wins.
    @(posedge clk);
    #1 sb.push_back(v_wait());
    @(negedge clk);
    reset = 1'b0;
    s     = 1'b0;

    foreach (directed[i]) run_instr(directed[i][4:2], directed[i][1:0], 1'b0);
    idle(2);

    // Back-to-back with s held high: exactly one WAIT cycle between them.
    run_instr(3'b101, 2'b00, 1'b1);
    run_instr(3'b110, 2'b10, 1'b1);
    run_instr(3'b011, 2'b00, 1'b1);
    run_instr(3'b100, 2'b00, 1'b1);
    run_instr(3'b000, 2'b00, 1'b1);
    idle(1);

    // Randomized instruction mix (halt excluded; it is exercised below).
    for (int k = 0; k < 80; k++) begin
      logic [2:0] oc;
      oc = 3'($urandom_range(0, 6));
      run_instr(oc, 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Reset while ADD is in its execute cycle.
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
    sb.push_back('0);
    v = '0; v.nsel = 3'b001; v.loada = 1'b1; sb.push_back(v);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 begin v = '0; v.loadc = 1'b1; sb.push_back(v); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 sb.push_back(v_wait());
    reset = 1'b0;
    @(negedge clk);

    // Reset and start together in WAIT.
    reset = 1'b1; s = 1'b1;
    @(posedge clk);
    #1 sb.push_back(v_wait());
    reset = 1'b0; s = 1'b0;
    @(negedge clk);

    // Halt: s is ignored until reset.
    opcode = 3'b111; op = 2'($urandom); s = 1'b1;
    @(posedge clk);
    #1 sb.push_back('0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      s = 1'($urandom);
      @(posedge clk);
      #1 begin v = '0; v.halted = 1'b1; sb.push_back(v); end
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 sb.push_back(v_wait());
    reset = 1'b0; s = 1'b0;
    @(negedge clk);
    run_instr(3'b110, 2'b10, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
